// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC front-end.
//   sample_t      : signed 16-bit PCM / windowed sample
//   coef_t        : signed 16-bit Q1.15 window coefficient (always >= 0)
//   hamming_coef  : elaboration-time Hamming window generator used to build
//                   the coefficient ROM
package mfcc_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [15:0] coef_t;

  localparam int FRAME_LEN_DEFAULT = 306;
  localparam int HOP_DEFAULT       = 102;
  localparam int FRAC_BITS_DEFAULT = 15;

  // Sequencer FSM encoding
  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  localparam real PI = 3.14159265358979323846;

  // min(32767, round(32768*(0.54-0.46*cos(2*pi*k/(n-1))))); the clamp keeps
  // the centre tap representable as a positive Q1.15 value.
  function automatic coef_t hamming_coef(input int k, input int n);
    real w;
    int  r;
    w = 32768.0 * (0.54 - 0.46 * $cos(2.0 * PI * real'(k) / real'(n - 1)));
    r = $rtoi(w + 0.5);
    if (r > 32'sd32767) begin
      r = 32'sd32767;
    end else begin
      r = r;
    end
    return coef_t'(r);
  endfunction

endpackage

// File: rtl/hamming_frame_sequencer_rom.sv
// Hamming coefficient ROM.
//   k    : coefficient index (0 .. FRAME_LEN-1 meaningful)
//   coef : Q1.15 coefficient, 0 for indices at or beyond FRAME_LEN
// The table is padded to a power of two so the index width matches exactly.
module hamming_coef_rom
  import mfcc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int K_W       = $clog2(FRAME_LEN + 1)
) (
  input  logic [K_W-1:0] k,
  output coef_t          coef
);

  localparam int DEPTH = 1 << K_W;

  coef_t table_s [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    assign table_s[g] = (g < FRAME_LEN) ? hamming_coef(g, FRAME_LEN) : coef_t'(16'sd0);
  end

  // Combinational coefficient lookup
  always_comb begin
    coef = table_s[k];
  end

endmodule

// File: rtl/hamming_frame_sequencer.sv
// Hamming frame sequencer: buffers the last FRAME_LEN input samples and,
// every HOP new samples, streams one windowed frame through a single
// 16x16 multiplier.
//   flush                      : sync discard of buffer state and current frame
//   in_sample/in_valid/in_ready: PCM input stream (stalled while emitting)
//   out_sample/out_valid/out_ready/out_first/out_last: windowed frame stream
//   frame_count                : frames fully emitted (wraps)
//   busy                       : a frame is being emitted
module hamming_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int HOP       = HOP_DEFAULT,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  sample_t     in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  output sample_t     out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_HOP   = CNT_W'(HOP);
  localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(FRAME_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] new_cnt_q, new_cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  sample_t          out_sample_q, out_sample_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic [15:0]      frame_count_q, frame_count_d;

  sample_t          sample_mem_q [FRAME_LEN];

  coef_t              coef_s;
  sample_t            rd_sample_s;
  logic signed [31:0] product_s;
  logic               in_hs_s;
  logic               out_hs_s;
  logic               load_s;
  logic [PTR_W-1:0]   wr_ptr_inc_s;
  logic [PTR_W-1:0]   rd_ptr_inc_s;

  hamming_coef_rom #(
    .FRAME_LEN (FRAME_LEN),
    .K_W       (CNT_W)
  ) u_coef_rom (
    .k    (k_q),
    .coef (coef_s)
  );

  assign in_ready    = (state_q != ST_EMIT);
  assign busy        = (state_q == ST_EMIT);
  assign out_sample  = out_sample_q;
  assign out_valid   = out_valid_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign frame_count = frame_count_q;

  // Handshakes, circular pointer increments and the windowing product
  always_comb begin
    in_hs_s      = in_valid & in_ready;
    out_hs_s     = out_valid_q & out_ready;
    wr_ptr_inc_s = (wr_ptr_q == PTR_LAST) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
    rd_ptr_inc_s = (rd_ptr_q == PTR_LAST) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
    rd_sample_s  = sample_mem_q[rd_ptr_q];
    product_s    = 32'(rd_sample_s) * 32'(coef_s);
    // Output register may take the next element when empty or being drained
    load_s       = (state_q == ST_EMIT) && (k_q != CNT_FRAME) && (!out_valid_q || out_ready);
  end

  // Next-state logic for the FSM, pointers and registered output stage
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    new_cnt_d     = new_cnt_q;
    k_d           = k_q;
    out_sample_d  = out_sample_q;
    out_valid_d   = out_valid_q;
    out_first_d   = out_first_q;
    out_last_d    = out_last_q;
    frame_count_d = frame_count_q;
    if (flush) begin
      state_d     = ST_PRIME;
      wr_ptr_d    = PTR_W'(0);
      rd_ptr_d    = PTR_W'(0);
      new_cnt_d   = CNT_W'(0);
      k_d         = CNT_W'(0);
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PRIME, ST_FILL: begin
          if (in_hs_s) begin
            wr_ptr_d = wr_ptr_inc_s;
            if (((state_q == ST_PRIME) && (new_cnt_q + CNT_W'(1) == CNT_FRAME)) ||
                ((state_q == ST_FILL)  && (new_cnt_q + CNT_W'(1) == CNT_HOP))) begin
              // Oldest sample sits at the post-write pointer
              state_d   = ST_EMIT;
              new_cnt_d = CNT_W'(0);
              k_d       = CNT_W'(0);
              rd_ptr_d  = wr_ptr_inc_s;
            end else begin
              new_cnt_d = new_cnt_q + CNT_W'(1);
            end
          end else begin
            new_cnt_d = new_cnt_q;
          end
        end
        ST_EMIT: begin
          if (load_s) begin
            out_sample_d = sample_t'(product_s >>> FRAC_BITS);
            out_first_d  = (k_q == CNT_W'(0));
            out_last_d   = (k_q == K_LAST);
            out_valid_d  = 1'b1;
            k_d          = k_q + CNT_W'(1);
            rd_ptr_d     = rd_ptr_inc_s;
          end else if (out_hs_s && out_last_q) begin
            // Final element accepted: frame complete, resume collecting input
            out_valid_d   = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_FILL;
            k_d           = CNT_W'(0);
          end else begin
            out_valid_d = out_valid_q;
          end
        end
        default: begin
          state_d     = ST_PRIME;
          wr_ptr_d    = PTR_W'(0);
          new_cnt_d   = CNT_W'(0);
          k_d         = CNT_W'(0);
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control and output-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PRIME;
      wr_ptr_q      <= PTR_W'(0);
      rd_ptr_q      <= PTR_W'(0);
      new_cnt_q     <= CNT_W'(0);
      k_q           <= CNT_W'(0);
      out_sample_q  <= sample_t'(16'sd0);
      out_valid_q   <= 1'b0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      new_cnt_q     <= new_cnt_d;
      k_q           <= k_d;
      out_sample_q  <= out_sample_d;
      out_valid_q   <= out_valid_d;
      out_first_q   <= out_first_d;
      out_last_q    <= out_last_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sample buffer; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (in_hs_s && !flush) begin
      sample_mem_q[wr_ptr_q] <= in_sample;
    end
  end

endmodule

// File: tb/tb_hamming_frame_sequencer.sv
// Self-checking bench for hamming_frame_sequencer. Four instances with
// different FRAME_LEN/HOP share stimulus; only the selected one sees
// in_valid/flush. Expected frames come from a history-of-samples model.
module tb_hamming_frame_sequencer;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_sample = 16'd0;
  logic [1:0]  sel = 2'd0;

  logic        in_valid_v [4];
  logic        flush_v [4];
  logic        in_ready_v [4];
  logic [15:0] out_sample_v [4];
  logic        out_valid_v [4];
  logic        out_first_v [4];
  logic        out_last_v [4];
  logic [15:0] frame_count_v [4];
  logic        busy_v [4];

  logic        in_ready_m, out_valid_m, out_first_m, out_last_m, busy_m;
  logic [15:0] out_sample_m, frame_count_m;

  int n_checks = 0;
  int n_errors = 0;
  int hist_q [4][$];
  int nacc [4];
  int efc [4];
  int obs [$];
  int ramp = 1;

  function automatic int fl_of(input int i);
    case (i)
      0: return 306;
      1: return 8;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int hp_of(input int i);
    case (i)
      0: return 102;
      1: return 4;
      2: return 1;
      default: return 6;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign in_valid_v[g] = in_valid & (sel == 2'(g));
    assign flush_v[g]    = flush & (sel == 2'(g));
    hamming_frame_sequencer #(
      .FRAME_LEN (fl_of(g)),
      .HOP       (hp_of(g)),
      .FRAC_BITS (15)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush_v[g]),
      .in_sample   (in_sample),
      .in_valid    (in_valid_v[g]),
      .in_ready    (in_ready_v[g]),
      .out_sample  (out_sample_v[g]),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_first   (out_first_v[g]),
      .out_last    (out_last_v[g]),
      .frame_count (frame_count_v[g]),
      .busy        (busy_v[g])
    );
  end

  always_comb begin
    in_ready_m    = in_ready_v[sel];
    out_valid_m   = out_valid_v[sel];
    out_first_m   = out_first_v[sel];
    out_last_m    = out_last_v[sel];
    busy_m        = busy_v[sel];
    out_sample_m  = out_sample_v[sel];
    frame_count_m = frame_count_v[sel];
  end

  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // Reference Hamming coefficient straight from the window definition
  function automatic int model_coef(input int k, input int n);
    real w;
    int  r;
    w = 32768.0 * (0.54 - 0.46 * $cos(2.0 * 3.14159265358979 * k / (n - 1)));
    r = $rtoi(w + 0.5);
    return (r > 32767) ? 32767 : r;
  endfunction

  function automatic int model_out(input int s, input int c);
    int p;
    p = s * c;
    return p >>> 15;
  endfunction

  function automatic bit frame_due(input int n, input int f, input int h);
    return (n == f) || ((n > f) && ((n - f) % h == 0));
  endfunction

  function automatic logic [15:0] gen_sample(input int mode);
    case (mode)
      1: return 16'h7fff;
      2: return 16'(ramp);
      3: return 16'h8000;
      4: return 16'hffff;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  function automatic void model_clear(input int i);
    hist_q[i].delete();
    nacc[i] = 0;
  endfunction

  // Drive random-valid input until the model says a frame is scheduled
  task automatic feed_frame(input int mode);
    int f, h, cyc, sv;
    bit due, v;
    logic [15:0] s;
    f = fl_of(sel); h = hp_of(sel); due = 1'b0; cyc = 0;
    while (!due && cyc < 4 * f + 200) begin
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      s = gen_sample(mode);
      in_valid = v; in_sample = s;
      if (v && in_ready_m) begin
        sv = int'($signed(s));
        hist_q[sel].push_back(sv);
        if (hist_q[sel].size() > f) void'(hist_q[sel].pop_front());
        nacc[sel]++;
        if (mode == 2) ramp++;
        due = frame_due(nacc[sel], f, h);
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (!due) begin n_errors++; $display("FAIL feed_timeout sel=%0d accepted=%0d", sel, nacc[sel]); end
    n_checks++;
    if (in_ready_m !== 1'b0) begin n_errors++; $display("FAIL in_ready_drop got %b exp 0", in_ready_m); end
    n_checks++;
    if (out_valid_m !== 1'b0) begin n_errors++; $display("FAIL bubble got out_valid=%b exp 0", out_valid_m); end
    n_checks++;
    if (busy_m !== 1'b1) begin n_errors++; $display("FAIL busy_emit got %b exp 1", busy_m); end
  endtask

  // Consume one frame with out_ready at pct% duty; optionally stop at index stop_at
  task automatic drain_frame(input int pct, input int stop_at, output bit stopped);
    int f, idx, cyc, got, prev, base;
    bit stall;
    int expv [$];
    f = fl_of(sel);
    base = hist_q[sel].size() - f;
    expv.delete();
    for (int j = 0; j < f; j++) expv.push_back(model_out(hist_q[sel][base + j], model_coef(j, f)));
    obs.delete();
    idx = 0; cyc = 0; stall = 1'b0; stopped = 1'b0; prev = 0;
    while (idx < f && cyc < 40 * f + 200) begin
      @(negedge clk);
      cyc++;
      got = $signed(out_sample_m);
      if (out_valid_m) begin
        if (stop_at == idx) begin
          out_ready = 1'b0;
          stopped = 1'b1;
          break;
        end
        n_checks++;
        if (got !== expv[idx]) begin n_errors++; $display("FAIL sample[%0d] got %0d exp %0d", idx, got, expv[idx]); end
        n_checks++;
        if (out_first_m !== (idx == 0)) begin n_errors++; $display("FAIL out_first[%0d] got %b exp %b", idx, out_first_m, idx == 0); end
        n_checks++;
        if (out_last_m !== (idx == f - 1)) begin n_errors++; $display("FAIL out_last[%0d] got %b exp %b", idx, out_last_m, idx == f - 1); end
        n_checks++;
        if (in_ready_m !== 1'b0) begin n_errors++; $display("FAIL in_ready_emit[%0d] got %b exp 0", idx, in_ready_m); end
        if (stall) begin
          n_checks++;
          if (got !== prev) begin n_errors++; $display("FAIL stall_hold[%0d] got %0d exp %0d", idx, got, prev); end
        end
        out_ready = ($urandom_range(0, 99) < pct);
        stall = !out_ready;
        prev = got;
        if (out_ready) begin
          obs.push_back(got);
          idx++;
        end
      end else begin
        n_checks++; n_errors++;
        $display("FAIL valid_gap[%0d] got out_valid=0 exp 1", idx);
        out_ready = ($urandom_range(0, 99) < pct);
      end
    end
    if (!stopped) begin
      n_checks++;
      if (idx != f) begin n_errors++; $display("FAIL drain_timeout got %0d outputs exp %0d", idx, f); end
      efc[sel]++;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid_m !== 1'b0) begin n_errors++; $display("FAIL end_valid got %b exp 0", out_valid_m); end
      n_checks++;
      if (in_ready_m !== 1'b1) begin n_errors++; $display("FAIL end_in_ready got %b exp 1", in_ready_m); end
      n_checks++;
      if (busy_m !== 1'b0) begin n_errors++; $display("FAIL end_busy got %b exp 0", busy_m); end
      n_checks++;
      if (frame_count_m !== 16'(efc[sel])) begin n_errors++; $display("FAIL frame_count got %0d exp %0d", frame_count_m, efc[sel]); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0 ||
          out_first_v[i] !== 1'b0 || out_last_v[i] !== 1'b0 || out_sample_v[i] !== 16'd0 ||
          frame_count_v[i] !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d] got rdy=%b vld=%b busy=%b first=%b last=%b smp=%0d fc=%0d exp 1 0 0 0 0 0 0",
                 i, in_ready_v[i], out_valid_v[i], busy_v[i], out_first_v[i], out_last_v[i], out_sample_v[i], frame_count_v[i]);
      end
    end
  endtask

  task automatic test_prime_const();
    bit st;
    sel = 2'd0;
    feed_frame(1);
    drain_frame(100, -1, st);
    n_checks++;
    if (obs.size() != 306) begin
      n_errors++; $display("FAIL prime_count got %0d exp 306", obs.size());
    end else begin
      n_checks += 2;
      if (obs[0] !== 2620) begin n_errors++; $display("FAIL prime_first got %0d exp 2620", obs[0]); end
      if (obs[153] !== 32766) begin n_errors++; $display("FAIL prime_centre got %0d exp 32766", obs[153]); end
      n_checks++;
      if (obs[305] !== 2620) begin n_errors++; $display("FAIL prime_last got %0d exp 2620", obs[305]); end
    end
  endtask

  task automatic test_overlap();
    bit st;
    sel = 2'd1;
    ramp = 1;
    for (int n = 0; n < 3; n++) begin
      feed_frame(2);
      drain_frame(100, -1, st);
    end
  endtask

  task automatic test_negative();
    bit st;
    sel = 2'd2;
    feed_frame(3);
    drain_frame(100, -1, st);
    n_checks++;
    if (obs.size() < 1 || obs[0] !== -2621) begin
      n_errors++; $display("FAIL neg_extreme got %0d exp -2621", (obs.size() > 0) ? obs[0] : 0);
    end
    for (int n = 0; n < 4; n++) begin
      feed_frame(4);
      drain_frame(100, -1, st);
    end
    n_checks++;
    if (obs.size() != 4 || obs[0] !== -1 || obs[3] !== -1) begin
      n_errors++; $display("FAIL neg_one_trunc got %0d,%0d exp -1,-1",
                           (obs.size() > 0) ? obs[0] : 0, (obs.size() > 3) ? obs[3] : 0);
    end
  endtask

  task automatic test_backpressure();
    bit st;
    sel = 2'd0;
    for (int n = 0; n < 3; n++) begin
      feed_frame(0);
      drain_frame(30, -1, st);
    end
  endtask

  task automatic test_back_to_back();
    bit st;
    sel = 2'd3;
    for (int n = 0; n < 3; n++) begin
      feed_frame(0);
      drain_frame((n == 1) ? 100 : 60, -1, st);
    end
  endtask

  task automatic test_flush();
    bit st;
    sel = 2'd0;
    feed_frame(0);
    drain_frame(100, 100, st);
    n_checks++;
    if (!st) begin n_errors++; $display("FAIL flush_reach got %b exp 1", st); end
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    model_clear(0);
    n_checks++;
    if (out_valid_m !== 1'b0 || out_last_m !== 1'b0) begin
      n_errors++; $display("FAIL flush_out got vld=%b last=%b exp 0 0", out_valid_m, out_last_m);
    end
    n_checks++;
    if (in_ready_m !== 1'b1 || busy_m !== 1'b0) begin
      n_errors++; $display("FAIL flush_state got rdy=%b busy=%b exp 1 0", in_ready_m, busy_m);
    end
    n_checks++;
    if (frame_count_m !== 16'(efc[0])) begin n_errors++; $display("FAIL flush_fc got %0d exp %0d", frame_count_m, efc[0]); end
    // Partial refill, then a flush that coincides with an input handshake
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sample = 16'($urandom_range(0, 65535));
    end
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_sample = 16'($urandom_range(0, 65535));
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    model_clear(0);
    feed_frame(0);
    drain_frame(100, -1, st);
  endtask

  task automatic test_async_reset();
    bit st;
    sel = 2'd1;
    feed_frame(0);
    drain_frame(100, 3, st);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_m !== 1'b0 || out_sample_m !== 16'd0 || out_first_m !== 1'b0 || out_last_m !== 1'b0 ||
        busy_m !== 1'b0 || in_ready_m !== 1'b1 || frame_count_m !== 16'd0) begin
      n_errors++;
      $display("FAIL async_reset got vld=%b smp=%0d first=%b last=%b busy=%b rdy=%b fc=%0d exp 0 0 0 0 0 1 0",
               out_valid_m, out_sample_m, out_first_m, out_last_m, busy_m, in_ready_m, frame_count_m);
    end
    #5 rst_n = 1'b1;
    #2 clk_run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      model_clear(i);
      efc[i] = 0;
    end
    ramp = 1;
    feed_frame(2);
    drain_frame(100, -1, st);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      nacc[i] = 0;
      efc[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_prime_const();
    test_overlap();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
